// File: rtl/clock_time_core.sv
// ============================================================================
// Module   : clock_time_core
// Purpose  : 24-hour BCD timekeeper with two-button set mode and registered
//            seven-segment / decimal-point outputs for a 4-digit multiplexer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module clock_time_core #(
    parameter int CLK_FREQ_HZ = 100_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_set,
    input  logic       btn_inc,
    output logic [6:0] dig1,
    output logic [6:0] dig2,
    output logic [6:0] dig3,
    output logic [6:0] dig4,
    output logic       decimal_place_1,
    output logic       decimal_place_2,
    output logic       decimal_place_3,
    output logic       decimal_place_4
);

    localparam int              c_PW    = $clog2(CLK_FREQ_HZ);
    localparam logic [c_PW-1:0] c_TERM  = c_PW'(CLK_FREQ_HZ - 1);
    localparam logic [c_PW-1:0] c_HALF  = c_PW'(CLK_FREQ_HZ / 2);
    localparam logic [6:0]      c_BLANK = 7'b1111111;
    localparam logic [6:0]      c_ZERO  = 7'b1000000;

    localparam logic [1:0] c_RUN      = 2'd0;
    localparam logic [1:0] c_SET_HOUR = 2'd1;
    localparam logic [1:0] c_SET_MIN  = 2'd2;

    logic [c_PW-1:0] r_presc, w_presc_nx;
    logic [1:0]      r_state, w_state_nx;
    logic [1:0]      r_ht, w_ht_nx, w_ht_inc;
    logic [3:0]      r_hu, w_hu_nx, w_hu_inc;
    logic [2:0]      r_mt, w_mt_nx, w_mt_inc;
    logic [3:0]      r_mu, w_mu_nx, w_mu_inc;
    logic [2:0]      r_st, w_st_nx;
    logic [3:0]      r_su, w_su_nx;
    logic            r_set_s1, r_set_s2, r_set_h;
    logic            r_inc_s1, r_inc_s2, r_inc_h;
    logic            w_set_edge, w_inc_edge, w_tick, w_half;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'b1000000;
            4'd1:    f_seg = 7'b1111001;
            4'd2:    f_seg = 7'b0100100;
            4'd3:    f_seg = 7'b0110000;
            4'd4:    f_seg = 7'b0011001;
            4'd5:    f_seg = 7'b0010010;
            4'd6:    f_seg = 7'b0000010;
            4'd7:    f_seg = 7'b1111000;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0010000;
            default: f_seg = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            {r_set_s1, r_set_s2, r_set_h} <= 3'b000;
            {r_inc_s1, r_inc_s2, r_inc_h} <= 3'b000;
        end else begin
            r_set_s1 <= btn_set;
            r_set_s2 <= r_set_s1;
            r_set_h  <= r_set_s2;
            r_inc_s1 <= btn_inc;
            r_inc_s2 <= r_inc_s1;
            r_inc_h  <= r_inc_s2;
        end
    end

    assign w_set_edge = r_set_s2 & ~r_set_h;
    assign w_inc_edge = r_inc_s2 & ~r_inc_h;
    assign w_tick     = (r_presc == c_TERM);
    assign w_half     = (r_presc < c_HALF);

    // Wrapped increments of the hour and minute fields, shared by carry and set paths
    always_comb begin
        w_ht_inc = r_ht;
        w_hu_inc = r_hu + 4'd1;
        if (r_ht == 2'd2 && r_hu == 4'd3) begin
            w_ht_inc = 2'd0;
            w_hu_inc = 4'd0;
        end else if (r_hu == 4'd9) begin
            w_ht_inc = r_ht + 2'd1;
            w_hu_inc = 4'd0;
        end
        w_mt_inc = r_mt;
        w_mu_inc = r_mu + 4'd1;
        if (r_mu == 4'd9) begin
            w_mu_inc = 4'd0;
            w_mt_inc = (r_mt == 3'd5) ? 3'd0 : r_mt + 3'd1;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_presc_nx = w_tick ? '0 : r_presc + 1'b1;
        w_ht_nx    = r_ht;
        w_hu_nx    = r_hu;
        w_mt_nx    = r_mt;
        w_mu_nx    = r_mu;
        w_st_nx    = r_st;
        w_su_nx    = r_su;
        case (r_state)
            c_RUN: begin
                if (w_tick) begin
                    if (r_su != 4'd9) begin
                        w_su_nx = r_su + 4'd1;
                    end else begin
                        w_su_nx = 4'd0;
                        if (r_st != 3'd5) begin
                            w_st_nx = r_st + 3'd1;
                        end else begin
                            w_st_nx = 3'd0;
                            w_mt_nx = w_mt_inc;
                            w_mu_nx = w_mu_inc;
                            if (r_mt == 3'd5 && r_mu == 4'd9) begin
                                w_ht_nx = w_ht_inc;
                                w_hu_nx = w_hu_inc;
                            end
                        end
                    end
                end
                if (w_set_edge) begin
                    w_state_nx = c_SET_HOUR;
                end
            end
            c_SET_HOUR: begin
                if (w_set_edge) begin
                    w_state_nx = c_SET_MIN;
                end else if (w_inc_edge) begin
                    w_ht_nx = w_ht_inc;
                    w_hu_nx = w_hu_inc;
                end
            end
            c_SET_MIN: begin
                // Re-entering RUN restarts the second so the first tick is a full period away
                if (w_set_edge) begin
                    w_state_nx = c_RUN;
                    w_presc_nx = '0;
                    w_st_nx    = 3'd0;
                    w_su_nx    = 4'd0;
                end else if (w_inc_edge) begin
                    w_mt_nx = w_mt_inc;
                    w_mu_nx = w_mu_inc;
                    w_st_nx = 3'd0;
                    w_su_nx = 4'd0;
                end
            end
            default: begin
                w_state_nx = c_RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_RUN;
            r_presc <= '0;
            r_ht    <= 2'd0;
            r_hu    <= 4'd0;
            r_mt    <= 3'd0;
            r_mu    <= 4'd0;
            r_st    <= 3'd0;
            r_su    <= 4'd0;
        end else begin
            r_state <= w_state_nx;
            r_presc <= w_presc_nx;
            r_ht    <= w_ht_nx;
            r_hu    <= w_hu_nx;
            r_mt    <= w_mt_nx;
            r_mu    <= w_mu_nx;
            r_st    <= w_st_nx;
            r_su    <= w_su_nx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dig1            <= c_ZERO;
            dig2            <= c_ZERO;
            dig3            <= c_ZERO;
            dig4            <= c_ZERO;
            decimal_place_2 <= 1'b1;
        end else begin
            dig1 <= (r_state == c_SET_HOUR && !w_half) ? c_BLANK : f_seg({2'b00, r_ht});
            dig2 <= (r_state == c_SET_HOUR && !w_half) ? c_BLANK : f_seg(r_hu);
            dig3 <= (r_state == c_SET_MIN  && !w_half) ? c_BLANK : f_seg({1'b0, r_mt});
            dig4 <= (r_state == c_SET_MIN  && !w_half) ? c_BLANK : f_seg(r_mu);
            decimal_place_2 <= (r_state == c_RUN) ? w_half : 1'b1;
        end
    end

    assign decimal_place_1 = 1'b0;
    assign decimal_place_3 = 1'b0;
    assign decimal_place_4 = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_clock_time_core.sv
// ============================================================================
// Module   : tb_clock_time_core
// Purpose  : Self-checking bench for clock_time_core against a seconds-count
//            reference model, directed scenarios plus random button traffic.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clock_time_core;

    localparam int CLK = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       btn_set = 1'b0;
    logic       btn_inc = 1'b0;
    logic [6:0] dig1, dig2, dig3, dig4;
    logic       decimal_place_1, decimal_place_2, decimal_place_3, decimal_place_4;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: time as seconds of the day, mode 0=RUN 1=SET_HOUR 2=SET_MIN
    int       m_tsec  = 0;
    int       m_presc = 0;
    int       m_state = 0;
    bit [2:0] m_sh    = '0;
    bit [2:0] m_ih    = '0;

    clock_time_core #(.CLK_FREQ_HZ(CLK)) dut (
        .clock(clock), .reset(reset), .btn_set(btn_set), .btn_inc(btn_inc),
        .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4),
        .decimal_place_1(decimal_place_1), .decimal_place_2(decimal_place_2),
        .decimal_place_3(decimal_place_3), .decimal_place_4(decimal_place_4)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [31:0] exp_out();
        int h, m;
        bit half;
        logic [6:0] d1, d2, d3, d4;
        logic dp2;
        h = m_tsec / 3600;
        m = (m_tsec / 60) % 60;
        half = (m_presc < CLK / 2);
        d1 = seg(h / 10); d2 = seg(h % 10); d3 = seg(m / 10); d4 = seg(m % 10);
        if (m_state == 1 && !half) begin d1 = 7'h7f; d2 = 7'h7f; end
        if (m_state == 2 && !half) begin d3 = 7'h7f; d4 = 7'h7f; end
        dp2 = (m_state == 0) ? half : 1'b1;
        return {d1, d2, d3, d4, 1'b0, dp2, 1'b0, 1'b0};
    endfunction

    task automatic model_update(input bit bs, input bit bi);
        bit se, ie, tick;
        int h, m, s;
        se = m_sh[1] & ~m_sh[2];
        ie = m_ih[1] & ~m_ih[2];
        m_sh = {m_sh[1:0], bs};
        m_ih = {m_ih[1:0], bi};
        tick = (m_presc == CLK - 1);
        m_presc = tick ? 0 : m_presc + 1;
        h = m_tsec / 3600;
        m = (m_tsec / 60) % 60;
        s = m_tsec % 60;
        case (m_state)
            0: begin
                if (tick) m_tsec = (m_tsec + 1) % 86400;
                if (se) m_state = 1;
            end
            1: begin
                if (se) m_state = 2;
                else if (ie) m_tsec = ((h + 1) % 24) * 3600 + m * 60 + s;
            end
            default: begin
                if (se) begin
                    m_state = 0;
                    m_presc = 0;
                    m_tsec  = h * 3600 + m * 60;
                end else if (ie) begin
                    m_tsec = h * 3600 + ((m + 1) % 60) * 60;
                end
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [31:0] e;
        if (reset) e = {{4{7'b1000000}}, 4'b0100};
        else       e = exp_out();
        @(posedge clock);
        if (reset) begin
            m_tsec = 0; m_presc = 0; m_state = 0; m_sh = '0; m_ih = '0;
        end else begin
            model_update(btn_set, btn_inc);
        end
        #1;
        check("outputs", {dig1, dig2, dig3, dig4, decimal_place_1, decimal_place_2,
                          decimal_place_3, decimal_place_4}, e);
    endtask

    task automatic press(input bit s, input bit i, input int hi);
        btn_set = s;
        btn_inc = i;
        repeat (hi) step();
        btn_set = 1'b0;
        btn_inc = 1'b0;
        repeat (2 + $urandom_range(0, 2)) step();
    endtask

    task automatic wait_presc(input int p);
        int n = 0;
        while (m_presc != p && n < 50) begin step(); n++; end
        check("wait_presc_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic set_hours(input int target);
        int k = (target - m_tsec / 3600 + 24) % 24;
        repeat (k) press(1'b0, 1'b1, $urandom_range(1, 3));
    endtask

    task automatic set_minutes(input int target);
        int k = (target - (m_tsec / 60) % 60 + 60) % 60;
        repeat (k) press(1'b0, 1'b1, $urandom_range(1, 3));
    endtask

    initial begin
        int n;
        // Reset, then a minute of running time
        step();
        reset = 1'b0;
        repeat (601) step();
        check("run600_dig4", {25'd0, dig4}, {25'd0, 7'b1111001});
        check("run600_dig123", {11'd0, dig1, dig2, dig3}, {11'd0, {3{7'b1000000}}});

        // Preload 23:59, let seconds climb to 59, then roll over
        press(1'b1, 1'b0, 1);
        set_hours(23);
        press(1'b1, 1'b0, 2);
        set_minutes(59);
        press(1'b1, 1'b0, 1);
        n = 0;
        while (m_tsec != 86399 && n < 1000) begin step(); n++; end
        check("reach_235959", 32'(n < 1000), 32'd1);
        n = 0;
        while (m_tsec != 0 && n < 20) begin step(); n++; end
        step();
        check("rollover", {4'd0, dig1, dig2, dig3, dig4}, {4'd0, {4{7'b1000000}}});

        // Hours wrap after 25 increments; minute 59 wraps without carry
        press(1'b1, 1'b0, 1);
        repeat (25) press(1'b0, 1'b1, 1);
        press(1'b1, 1'b0, 1);
        set_minutes(59);
        press(1'b0, 1'b1, 1);
        press(1'b1, 1'b0, 1);
        repeat (12) step();
        check("set_0100", {4'd0, dig1, dig2, dig3, dig4},
              {4'd0, 7'b1000000, 7'b1111001, 7'b1000000, 7'b1000000});

        // Tick coinciding with a set edge in RUN
        wait_presc(7);
        press(1'b1, 1'b0, 1);
        // Held button advances exactly once
        press(1'b1, 1'b0, 50);
        // Leaving SET_MIN on a would-be tick cycle
        wait_presc(7);
        press(1'b1, 1'b0, 1);
        repeat (25) step();
        // Both buttons together in SET_HOUR
        press(1'b1, 1'b0, 1);
        press(1'b1, 1'b1, 1);
        press(1'b1, 1'b0, 1);
        press(1'b1, 1'b0, 1);
        set_hours(12);
        press(1'b1, 1'b0, 1);
        set_minutes(34);
        repeat (7) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_out", {dig1, dig2, dig3, dig4, decimal_place_2},
              {{4{7'b1000000}}, 1'b1});
        step();
        check("post_reset", {dig1, dig2, dig3, dig4, decimal_place_2},
              {{4{7'b1000000}}, 1'b1});

        // Random button traffic
        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2:    press(1'b1, 1'b0, $urandom_range(1, 4));
                3, 4, 5, 6: press(1'b0, 1'b1, $urandom_range(1, 4));
                7:          press(1'b1, 1'b1, $urandom_range(1, 4));
                default:    repeat ($urandom_range(1, 40)) step();
            endcase
        end
        repeat (30) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
